// File: rtl/multi_port_write_arbiter_pkg.sv
// Shared helpers for the multi-port write arbiter and the FIFO-side blocks that
// size their lane-count fields from the same constant.
package multi_port_write_arbiter_pkg;

    // Ceiling log2, never below 1 so single-entry pointers still get a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

    localparam int unsigned MPWA_DEF_NUM_PORTS = 2;
    localparam int unsigned LANE_CNT_W         = clog2(MPWA_DEF_NUM_PORTS + 1);

endpackage

// File: rtl/multi_port_write_arbiter_rr_priority_picker.sv
// Returns the first NUM_PORTS set bits of a request mask, scanning upward from
// a start index and wrapping modulo NUM_REQ; entry p is the p-th hit.
module rr_priority_picker
    import multi_port_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_W     = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]                mask_i,
    input  logic [IDX_W-1:0]                  start_i,
    output logic [NUM_PORTS-1:0][IDX_W-1:0]   idx_o,
    output logic [NUM_PORTS-1:0]              vld_o
);

    always_comb begin
        logic [31:0] pos;
        logic [31:0] found;
        idx_o = '0;
        vld_o = '0;
        found = '0;
        pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = 32'(start_i) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (mask_i[pos[IDX_W-1:0]]) begin
                for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                    if (found == p) begin
                        idx_o[p] = pos[IDX_W-1:0];
                        vld_o[p] = 1'b1;
                    end
                end
                found = found + 1;
            end
        end
    end

endmodule

// File: rtl/multi_port_write_arbiter.sv
// Packs up to K valid requesters onto the ready prefix of FIFO write lanes:
// urgent (starved) requesters first by index, then round-robin. Stats counters exist only with MPWA_STATS_EN.
module multi_port_write_arbiter
    import multi_port_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 8,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_PORTS-1:0]              fifo_wr_en,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   fifo_wr_data,
    input  logic [NUM_PORTS-1:0]              fifo_wr_ready,
    output logic [NUM_REQ*STAT_WIDTH-1:0]     stat_grants,
    output logic [STAT_WIDTH-1:0]             stat_stalls
);

    localparam int unsigned IW = clog2(NUM_REQ);
    localparam int unsigned WW = clog2(MAX_WAIT + 1);
    localparam int unsigned KW = clog2(NUM_PORTS + 1);

    logic [IW-1:0]                          rr_q, rr_d;
    logic [NUM_REQ-1:0][WW-1:0]             wait_q, wait_d;
    logic [NUM_REQ-1:0]                     urgent, normal;
    logic [NUM_PORTS-1:0][IW-1:0]           u_idx, n_idx, lane_idx;
    logic [NUM_PORTS-1:0]                   u_vld, n_vld, lane_vld, lane_norm;
    logic [KW-1:0]                          k_lanes, n_urg;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   lane_data;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++)
            urgent[i] = req_valid[i] && (wait_q[i] == WW'(MAX_WAIT));
        normal = req_valid & ~urgent;
    end

    rr_priority_picker #(.NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS), .IDX_W(IW)) u_urgent_pick (
        .mask_i (urgent),
        .start_i('0),
        .idx_o  (u_idx),
        .vld_o  (u_vld)
    );

    rr_priority_picker #(.NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS), .IDX_W(IW)) u_normal_pick (
        .mask_i (normal),
        .start_i(rr_q),
        .idx_o  (n_idx),
        .vld_o  (n_vld)
    );

    // Urgent picks fill lanes 0..n_urg-1; normal pick m lands on lane m+n_urg.
    always_comb begin
        logic blocked;
        blocked   = 1'b0;
        k_lanes   = '0;
        n_urg     = '0;
        lane_vld  = '0;
        lane_norm = '0;
        lane_idx  = '0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            blocked = blocked | ~fifo_wr_ready[j];
            if (!blocked) k_lanes = k_lanes + 1'b1;
            if (u_vld[j]) n_urg = n_urg + 1'b1;
        end
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (j < 32'(k_lanes)) begin
                if (u_vld[j]) begin
                    lane_vld[j] = 1'b1;
                    lane_idx[j] = u_idx[j];
                end else begin
                    for (int unsigned m = 0; m < NUM_PORTS; m++) begin
                        if (n_vld[m] && (m + 32'(n_urg) == j)) begin
                            lane_vld[j]  = 1'b1;
                            lane_norm[j] = 1'b1;
                            lane_idx[j]  = n_idx[m];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        lane_data = '0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (lane_vld[j] && (lane_idx[j] == IW'(i))) begin
                    req_ready[i] = 1'b1;
                    lane_data[j] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign fifo_wr_en   = lane_vld;
    assign fifo_wr_data = lane_data;

    // Highest granted normal lane is the last round-robin grantee.
    always_comb begin
        rr_d = rr_q;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (lane_vld[j] && lane_norm[j])
                rr_d = (32'(lane_idx[j]) == NUM_REQ - 1) ? '0 : lane_idx[j] + 1'b1;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] || req_ready[i])
                wait_d[i] = '0;
            else if (wait_q[i] != WW'(MAX_WAIT))
                wait_d[i] = wait_q[i] + 1'b1;
            else
                wait_d[i] = wait_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q   <= '0;
            wait_q <= '0;
        end else begin
            rr_q   <= rr_d;
            wait_q <= wait_d;
        end
    end

`ifdef MPWA_STATS_EN
    logic [NUM_REQ-1:0][STAT_WIDTH-1:0] grants_q;
    logic [STAT_WIDTH-1:0]              stalls_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grants_q <= '0;
            stalls_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (grants_q[i] != '1))
                    grants_q[i] <= grants_q[i] + 1'b1;
            end
            if ((|req_valid) && !(|req_ready) && (stalls_q != '1))
                stalls_q <= stalls_q + 1'b1;
        end
    end

    assign stat_grants = grants_q;
    assign stat_stalls = stalls_q;
`else
    assign stat_grants = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_multi_port_write_arbiter.sv
// Self-checking bench: directed vector table, hand-written urgency/reset
// sequences, then random traffic against a queue-based reference model.
module tb_multi_port_write_arbiter;

    localparam int N  = 4;
    localparam int P  = 2;
    localparam int DW = 32;
    localparam int MW = 2;
    localparam int SW = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N*DW-1:0]     req_data;
    logic [N-1:0]        req_ready;
    logic [P-1:0]        fifo_wr_en;
    logic [P*DW-1:0]     fifo_wr_data;
    logic [P-1:0]        fifo_wr_ready;
    logic [N*SW-1:0]     stat_grants;
    logic [SW-1:0]       stat_stalls;

    always #5 clk = ~clk;

    multi_port_write_arbiter #(
        .NUM_REQ(N), .NUM_PORTS(P), .DATA_WIDTH(DW), .MAX_WAIT(MW), .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_ready(fifo_wr_ready),
        .stat_grants(stat_grants), .stat_stalls(stat_stalls)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference state: round-robin start, per-requester wait, stats.
    int m_rr;
    int m_wait [N];
    int m_gr   [N];
    int m_st;

    typedef struct {
        logic [N-1:0] v;
        logic [P-1:0] r;
        logic [N-1:0] rdy;
        logic [P-1:0] en;
    } vec_t;

    vec_t tab [10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_rr = 0;
        m_st = 0;
        for (int i = 0; i < N; i++) begin
            m_wait[i] = 0;
            m_gr[i]   = 0;
        end
    endtask

    // Called one time unit after a posedge; checks mid-cycle, then advances the model.
    task automatic step(input logic [N-1:0] v, input logic [P-1:0] r, input logic rst,
                        input logic [N-1:0] t_rdy, input logic [P-1:0] t_en, input bit use_tab);
        int k, nu, ng, last_norm;
        int order[$];
        logic [N-1:0]    e_rdy;
        logic [P-1:0]    e_en;
        logic [P*DW-1:0] e_data;
        logic [N*SW-1:0] e_sg;
        logic [SW-1:0]   e_ss;
        req_valid     = v;
        fifo_wr_ready = r;
        rst_n         = rst;
        req_data      = {$urandom, $urandom, $urandom, $urandom};
        #4;
        k = 0;
        while (k < P && r[k]) k++;
        for (int i = 0; i < N; i++)
            if (v[i] && m_wait[i] == MW) order.push_back(i);
        nu = order.size();
        for (int j = 0; j < N; j++) begin
            int i;
            i = (m_rr + j) % N;
            if (v[i] && m_wait[i] != MW) order.push_back(i);
        end
        e_rdy = '0; e_en = '0; e_data = '0; ng = 0; last_norm = -1;
        for (int j = 0; j < k && j < order.size(); j++) begin
            e_en[j] = 1'b1;
            e_rdy[order[j]] = 1'b1;
            e_data[j*DW +: DW] = req_data[order[j]*DW +: DW];
            ng++;
            if (j >= nu) last_norm = order[j];
        end
`ifdef MPWA_STATS_EN
        for (int i = 0; i < N; i++) e_sg[i*SW +: SW] = m_gr[i][SW-1:0];
        e_ss = m_st[SW-1:0];
`else
        e_sg = '0;
        e_ss = '0;
`endif
        check("fifo_wr_en", fifo_wr_en, e_en);
        check("req_ready", req_ready, e_rdy);
        check("fifo_wr_data", fifo_wr_data, e_data);
        check("stat_grants", stat_grants, e_sg);
        check("stat_stalls", stat_stalls, e_ss);
        if (use_tab) begin
            check("tab_en", fifo_wr_en, t_en);
            check("tab_ready", req_ready, t_rdy);
        end
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && !e_rdy[i]) m_wait[i] = (m_wait[i] + 1 > MW) ? MW : m_wait[i] + 1;
                else m_wait[i] = 0;
                if (e_rdy[i] && m_gr[i] < (1 << SW) - 1) m_gr[i]++;
            end
            if (v != 0 && ng == 0 && m_st < (1 << SW) - 1) m_st++;
            if (last_norm >= 0) m_rr = (last_norm + 1) % N;
        end
        #1;
    endtask

    initial begin
        // v, ready, expected req_ready, expected fifo_wr_en
        tab[0] = '{4'b1111, 2'b11, 4'b0011, 2'b11};
        tab[1] = '{4'b1111, 2'b11, 4'b1100, 2'b11};
        tab[2] = '{4'b0000, 2'b10, 4'b0000, 2'b00};
        tab[3] = '{4'b1111, 2'b10, 4'b0000, 2'b00};
        tab[4] = '{4'b1111, 2'b10, 4'b0000, 2'b00};
        tab[5] = '{4'b0000, 2'b11, 4'b0000, 2'b00};
        tab[6] = '{4'b0011, 2'b11, 4'b0011, 2'b11};
        tab[7] = '{4'b1010, 2'b01, 4'b1000, 2'b01};
        tab[8] = '{4'b1010, 2'b01, 4'b0010, 2'b01};
        tab[9] = '{4'b0000, 2'b00, 4'b0000, 2'b00};

        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        fifo_wr_ready = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_en", fifo_wr_en, '0);
        check("reset_ready", req_ready, '0);
        check("reset_stat_grants", stat_grants, '0);
        check("reset_stat_stalls", stat_stalls, '0);

        for (int t = 0; t < 10; t++)
            step(tab[t].v, tab[t].r, 1'b1, tab[t].rdy, tab[t].en, 1'b1);

        // Reset mid-stream: grants restart from req0.
        step(4'b1111, 2'b11, 1'b1, '0, '0, 1'b0);
        step(4'b1111, 2'b11, 1'b0, '0, '0, 1'b0);
        step(4'b1111, 2'b01, 1'b1, 4'b0001, 2'b01, 1'b1);

        // req3 starved for MAX_WAIT cycles overtakes round-robin choice req2.
        step(4'b0000, 2'b00, 1'b0, '0, '0, 1'b0);
        step(4'b1001, 2'b01, 1'b1, 4'b0001, 2'b01, 1'b1);
        step(4'b1010, 2'b01, 1'b1, 4'b0010, 2'b01, 1'b1);
        step(4'b1100, 2'b01, 1'b1, 4'b1000, 2'b01, 1'b1);
        step(4'b0100, 2'b01, 1'b1, 4'b0100, 2'b01, 1'b1);

        for (int c = 0; c < 3000; c++)
            step(4'($urandom), 2'($urandom), ($urandom_range(0, 199) != 0), '0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/multi_port_write_arbiter.md
MULTI_PORT_WRITE_ARBITER -- requirements
Module: multi_port_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of upstream requesters.
REQ-002 SHALL have parameter NUM_PORTS, default 2, meaning number of downstream FIFO write lanes (NUM_PORTS <= NUM_REQ).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning payload width per requester/lane.
REQ-004 SHALL have parameter MAX_WAIT, default 8, meaning stall cycles before a requester becomes urgent (>= 1).
REQ-005 SHALL have parameter STAT_WIDTH, default 16, meaning width of each statistics counter.
REQ-006 SHALL use one clock; reset is synchronous and active-low; ports clk and rst_n, both 1-bit inputs, listed first.
REQ-007 SHALL have ports req_valid in NUM_REQ, req_data in NUM_REQ*DATA_WIDTH (requester i at bits i*DATA_WIDTH +: DATA_WIDTH), and req_ready out NUM_REQ.
REQ-008 SHALL have ports fifo_wr_en out NUM_PORTS, fifo_wr_data out NUM_PORTS*DATA_WIDTH, and fifo_wr_ready in NUM_PORTS, where fifo_wr_ready is the FIFO per-lane ready.
REQ-009 SHALL have ports stat_grants out NUM_REQ*STAT_WIDTH (per-requester accepted-word count) and stat_stalls out STAT_WIDTH (starved-cycle count).

Function
REQ-010 SHALL compute K = number of consecutive asserted fifo_wr_ready bits starting at lane 0; lanes at or above the first deasserted bit are unusable this cycle.
REQ-011 SHALL select at most K requesters with req_valid=1 per cycle, combinationally, zero-cycle latency.
REQ-012 SHALL order selection as follows: first, urgent requesters in ascending index order; then, non-urgent requesters in round-robin order starting at rr_ptr and wrapping modulo NUM_REQ.
REQ-013 SHALL map the j-th selected requester to lane j: fifo_wr_en[j]=1, fifo_wr_data lane j = that requester's req_data, and req_ready=1 for that requester.
REQ-014 SHALL drive fifo_wr_en=0 and fifo_wr_data=0 on unused lanes; req_ready=0 for unselected requesters.
REQ-015 SHALL never assert req_ready[i] while req_valid[i]=0, and a transfer occurs exactly when req_valid&req_ready.
REQ-016 SHALL update rr_ptr (width clog2(NUM_REQ)) on any cycle with >=1 non-urgent grant to (index of last non-urgent grantee + 1) mod NUM_REQ; rr_ptr is otherwise unchanged.
REQ-017 SHALL keep a wait counter per requester: +1 when req_valid=1 and req_ready=0, saturating at MAX_WAIT; cleared when granted or when req_valid=0.
REQ-018 SHALL treat a requester as urgent when its wait counter equals MAX_WAIT.
REQ-019 SHALL, when K=0, grant nothing, increment wait counters of all valid requesters, and leave rr_ptr unchanged.
REQ-020 SHALL behave identically under simultaneous urgency of more than K requesters: the lowest indices are served, and the rest stay urgent.

Reset
REQ-021 SHALL, when rst_n=0 at a clk edge, set rr_ptr=0, clear all wait counters, and clear all statistics counters.
REQ-022 SHALL drive combinational outputs from the reset state of registers, so the first cycle after reset arbitrates from rr_ptr=0 with no urgent requesters.
REQ-023 SHALL discard reset mid-operation wait and priority history entirely; no partial grant is retained.

Configuration
REQ-024 SHALL compile the statistics counters only when macro MPWA_STATS_EN is defined.
REQ-025 SHALL, with MPWA_STATS_EN defined, have stat_grants[i] increment per accepted word of requester i and stat_stalls increment per cycle with any req_valid=1 and zero grants, both saturating at all-ones.
REQ-026 SHALL, without MPWA_STATS_EN, keep the stat_grants and stat_stalls ports present and tie them to 0, with no counter flops.

Structure
REQ-027 SHALL place in a shared package the clog2 helper function and the lane-count width constant, for reuse by FIFO-side blocks.
REQ-028 SHALL use one sub-module, rr_priority_picker, to return the next NUM_PORTS valid indices from a start pointer over a request mask; the top instantiates it for the urgent mask (pointer 0) and the normal mask (pointer rr_ptr).

Verification
REQ-029 SHALL cover: all 4 valid, fifo_wr_ready=2'b11, rr_ptr=0 -> cycle 1 grants req0→lane0 and req1→lane1; cycle 2 grants req2 and req3; rr_ptr returns to 0.
REQ-030 SHALL cover: fifo_wr_ready=2'b10 -> K=0, no fifo_wr_en, all req_ready=0, stat_stalls +1 per cycle.
REQ-031 SHALL cover: fifo_wr_ready=2'b01, req1 and req3 valid, rr_ptr=2 -> req3 granted on lane0 and rr_ptr becomes 0.
REQ-032 SHALL cover: MAX_WAIT=2, req3 valid and held off for 2 cycles by a stream from req0..2 with K=1 -> on the 3rd cycle req3 is granted first as urgent.
REQ-033 SHALL cover: rst_n=0 for 1 cycle mid-stream with counters nonzero -> next cycle rr_ptr=0, stats=0, and grants restart from req0.
REQ-034 SHALL cover: build without MPWA_STATS_EN -> stat outputs stay 0 under full traffic while grant behaviour is unchanged.
